// File: rtl/stream_burst_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_burst_fifo_if
// Description : Valid/ready handshake bundle for the burst FIFO's input
//               stream and its burst-framed output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_burst_fifo_if #(
    parameter int DW = 32
);
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_o;

    // FIFO side
    modport slave (
        input  s_data_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_valid_o, m_last_o
    );

    // Producer/consumer side
    modport master (
        output s_data_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_valid_o, m_last_o
    );
endinterface
`default_nettype wire

// File: rtl/stream_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_burst_fifo
// Description : First-word-fall-through FIFO that frames its output into
//               fixed-length bursts and flags when a whole burst is resident.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_burst_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    stream_burst_fifo_if.slave       bus,
    output logic                     burst_avail_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [LW-1:0] level_q, level_d;
    logic          rst_q;

    logic          w_wr;
    logic          w_rd;
    logic          w_s_ready;
    logic          w_m_valid;

    // Ready stays low for one cycle after reset so the producer never sees a
    // handshake accepted by a FIFO that is still coming out of reset.
    assign w_s_ready = (level_q != LW'(DEPTH)) & ~rst_q;
    assign w_m_valid = (level_q != '0);
    assign w_wr      = bus.s_valid_i & w_s_ready;
    assign w_rd      = w_m_valid & bus.m_ready_i;

    assign bus.s_ready_o = w_s_ready;
    assign bus.m_valid_o = w_m_valid;
    assign bus.m_data_o  = mem_q[rp_q];
    assign level_o       = level_q;
    assign burst_avail_o = (level_q >= LW'(BURST));

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        if (w_wr) begin
            wp_d = wp_q + 1'b1;
        end
        if (w_rd) begin
            rp_d = rp_q + 1'b1;
        end
        if (w_wr && !w_rd) begin
            level_d = level_q + 1'b1;
        end else if (w_rd && !w_wr) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once level is zero.
    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            mem_q[wp_q] <= bus.s_data_i;
        end
    end

    generate
        if (BURST > 1) begin : g_beat
            localparam int BW = $clog2(BURST);
            logic [BW-1:0] beat_q, beat_d;

            always_comb begin
                beat_d = beat_q;
                if (w_rd) begin
                    beat_d = (beat_q == BW'(BURST - 1)) ? '0 : beat_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    beat_q <= '0;
                end else begin
                    beat_q <= beat_d;
                end
            end

            assign bus.m_last_o = w_m_valid & (beat_q == BW'(BURST - 1));
        end else begin : g_single_beat
            assign bus.m_last_o = w_m_valid;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_stream_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_burst_fifo
// Description : Directed self-checking bench for stream_burst_fifo, with a
//               queue reference model and a BURST=1/DEPTH=4 second instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_burst_fifo;
    logic       clk;
    logic       rst;
    logic       avail_a;
    logic [6:0] level_a;
    logic       avail_b;
    logic [2:0] level_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [$];
    int          mbeat = 0;
    bit          mrstq = 1'b1;

    stream_burst_fifo_if #(.DW(32)) a_if ();
    stream_burst_fifo_if #(.DW(32)) b_if ();

    stream_burst_fifo #(.DW(32), .DEPTH(64), .BURST(16)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if), .burst_avail_o(avail_a), .level_o(level_a)
    );

    stream_burst_fifo #(.DW(32), .DEPTH(4), .BURST(1)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if), .burst_avail_o(avail_b), .level_o(level_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every output of dut_a against the reference queue.
    task automatic cmp_all();
        int n;
        n = mq.size();
        chk("level", 64'(level_a), 64'(n));
        chk("m_valid", 64'(a_if.m_valid_o), 64'(n != 0));
        chk("s_ready", 64'(a_if.s_ready_o), 64'(n != 64 && !mrstq));
        chk("burst_avail", 64'(avail_a), 64'(n >= 16));
        if (n != 0) begin
            chk("m_data", 64'(a_if.m_data_o), 64'(mq[0]));
            chk("m_last", 64'(a_if.m_last_o), 64'(mbeat == 15));
        end else begin
            chk("m_last_empty", 64'(a_if.m_last_o), 64'd0);
        end
    endtask

    task automatic cyc(input bit sv, input logic [31:0] sd, input bit mr);
        bit wr;
        bit rd;
        a_if.s_valid_i = sv;
        a_if.s_data_i  = sd;
        a_if.m_ready_i = mr;
        wr = sv && (mq.size() != 64) && !mrstq;
        rd = mr && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (rd) begin
            void'(mq.pop_front());
            mbeat = (mbeat == 15) ? 0 : mbeat + 1;
        end
        if (wr) mq.push_back(sd);
        mrstq = 1'b0;
        a_if.s_valid_i = 1'b0;
        a_if.m_ready_i = 1'b0;
        cmp_all();
    endtask

    // Handshakes are offered during reset; none of them may land.
    task automatic do_reset(input int n);
        rst            = 1'b1;
        a_if.s_valid_i = 1'b1;
        a_if.s_data_i  = 32'hBAD0_BAD0;
        a_if.m_ready_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst            = 1'b0;
        a_if.s_valid_i = 1'b0;
        a_if.m_ready_i = 1'b0;
        mq.delete();
        mbeat = 0;
        mrstq = 1'b1;
        cmp_all();
    endtask

    initial begin
        int r;
        rst            = 1'b1;
        a_if.s_valid_i = 1'b0;
        a_if.s_data_i  = '0;
        a_if.m_ready_i = 1'b0;
        b_if.s_valid_i = 1'b0;
        b_if.s_data_i  = '0;
        b_if.m_ready_i = 1'b0;

        // Reset and its one-cycle ready hold-off
        do_reset(3);
        chk("rst_level", 64'(level_a), 64'd0);
        chk("rst_s_ready", 64'(a_if.s_ready_o), 64'd0);
        chk("rst_m_valid", 64'(a_if.m_valid_o), 64'd0);
        cyc(0, 0, 0);
        chk("rst_ready_back", 64'(a_if.s_ready_o), 64'd1);

        // One burst in, then drained with last on the 16th beat
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) chk("avail_at15", 64'(avail_a), 64'd0);
            cyc(1, 32'(i), 0);
        end
        chk("level16", 64'(level_a), 64'd16);
        chk("avail16", 64'(avail_a), 64'd1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 64'(a_if.m_data_o), 64'(i + 1));
            chk("drain_last", 64'(a_if.m_last_o), 64'(i == 15));
            cyc(0, 0, 1);
        end
        chk("drained", 64'(level_a), 64'd0);

        // Fill to full, refused word, no write-through, then full drain
        for (int i = 0; i < 64; i++) cyc(1, 32'h100 + 32'(i), 0);
        chk("full_level", 64'(level_a), 64'd64);
        chk("full_ready", 64'(a_if.s_ready_o), 64'd0);
        cyc(1, 32'hDEAD, 0);
        chk("refused", 64'(level_a), 64'd64);
        cyc(1, 32'hBEEF, 1);
        chk("no_wthru_level", 64'(level_a), 64'd63);
        chk("ready_after_rd", 64'(a_if.s_ready_o), 64'd1);
        for (int i = 0; i < 63; i++) begin
            chk("full_drain", 64'(a_if.m_data_o), 64'h101 + 64'(i));
            cyc(0, 0, 1);
        end
        chk("full_empty", 64'(a_if.m_valid_o), 64'd0);

        // Streaming at full rate; 80 reads so far keeps beat aligned
        for (int i = 0; i < 200; i++) begin
            if (i > 0) begin
                chk("stream_data", 64'(a_if.m_data_o), 64'h1000 + 64'(i - 1));
                chk("stream_last", 64'(a_if.m_last_o), 64'(((i - 1) % 16) == 15));
            end
            cyc(1, 32'h1000 + 32'(i), 1);
            chk("stream_level", 64'(level_a), 64'd1);
        end
        cyc(0, 0, 1);

        // Random traffic with pointer wrap
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
        end
        while (mq.size() != 0) cyc(0, 0, 1);

        // Park at level 37, beat 5, then reset mid-burst
        r = (5 - mbeat + 16) % 16;
        for (int i = 0; i < 37 + r; i++) cyc(1, 32'h3000 + 32'(i), 0);
        for (int i = 0; i < r; i++) cyc(0, 0, 1);
        chk("pre_rst_level", 64'(level_a), 64'd37);
        do_reset(1);
        chk("mid_rst_level", 64'(level_a), 64'd0);
        chk("mid_rst_valid", 64'(a_if.m_valid_o), 64'd0);
        chk("mid_rst_ready", 64'(a_if.s_ready_o), 64'd0);
        cyc(0, 0, 0);
        chk("mid_rst_ready2", 64'(a_if.s_ready_o), 64'd1);
        for (int i = 0; i < 20; i++) cyc(1, 32'h2000 + 32'(i), 0);
        for (int i = 0; i < 16; i++) begin
            chk("post_rst_data", 64'(a_if.m_data_o), 64'h2000 + 64'(i));
            chk("post_rst_last", 64'(a_if.m_last_o), 64'(i == 15));
            cyc(0, 0, 1);
        end

        // BURST=1, DEPTH=4 instance
        chk("b_empty_last", 64'(b_if.m_last_o), 64'd0);
        chk("b_empty_avail", 64'(avail_b), 64'd0);
        for (int i = 0; i < 5; i++) begin
            b_if.s_valid_i = 1'b1;
            b_if.s_data_i  = 32'h50 + 32'(i);
            @(posedge clk);
            #1;
            chk("b_level", 64'(level_b), 64'((i < 4) ? i + 1 : 4));
            chk("b_last", 64'(b_if.m_last_o), 64'd1);
            chk("b_avail", 64'(avail_b), 64'd1);
        end
        b_if.s_valid_i = 1'b0;
        chk("b_full", 64'(b_if.s_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("b_data", 64'(b_if.m_data_o), 64'h50 + 64'(i));
            b_if.m_ready_i = 1'b1;
            @(posedge clk);
            #1;
            b_if.m_ready_i = 1'b0;
            chk("b_last_v", 64'(b_if.m_last_o), 64'(i != 3));
            chk("b_avail_v", 64'(avail_b), 64'(i != 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
